// File: rtl/fetch_sequencer.sv
//=============================================================================
// fetch_sequencer : arbitrates boot, branch redirect, hazard stall and
//                   interrupt entry into one fetch-stage PC update per cycle.
// Optional feature macro: FETCH_SEQ_STALL_CNT_EN (stall cycle counter).
// Revision: 1.0 - initial release
//=============================================================================
`default_nettype none

module fetch_sequencer #(
   parameter int unsigned          PC_WIDTH        = 32,
   parameter logic [PC_WIDTH-1:0]  RESET_PC        = PC_WIDTH'(32),
   parameter logic [PC_WIDTH-1:0]  INT_VECTOR_BASE = '0,
   parameter int unsigned          NUM_INT         = 4,
   parameter int unsigned          DRAIN_CYCLES    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall_req,
   input  logic                branch_req,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic [PC_WIDTH-1:0] pc_plus_one_in,
   input  logic [NUM_INT-1:0]  int_req,
   input  logic                int_done,
   output logic                pc_enable,
   output logic                pc_write,
   output logic [PC_WIDTH-1:0] pc_write_back_value,
   output logic                clear_instruction,
   output logic [PC_WIDTH-1:0] saved_pc,
   output logic [NUM_INT-1:0]  int_ack,
   output logic                int_active,
   output logic [15:0]         stall_cycles
);

   localparam int unsigned IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
   localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      S_BOOT   = 2'd0,
      S_RUN    = 2'd1,
      S_DRAIN  = 2'd2,
      S_VECTOR = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PC_WIDTH-1:0] saved_q, saved_d;
   logic                active_q, active_d;

   logic [IDX_W-1:0]    w_low_idx;
   logic                w_take_int;
   logic [PC_WIDTH-1:0] w_vec_addr;
   logic                w_pe, w_pw, w_clr;
   logic [PC_WIDTH-1:0] w_val;
   logic [NUM_INT-1:0]  w_ack;

   // Descending scan so the lowest set request is the one left standing.
   always_comb begin
      w_low_idx = '0;
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         if (int_req[i]) begin
            w_low_idx = IDX_W'(i);
         end
      end
   end

   assign w_take_int = (|int_req) & ~active_q & ~stall_req;
   assign w_vec_addr = INT_VECTOR_BASE + PC_WIDTH'(idx_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_BOOT;
         cnt_q    <= '0;
         idx_q    <= '0;
         saved_q  <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         saved_q  <= saved_d;
         active_q <= active_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      saved_d  = saved_q;
      active_d = active_q;
      w_pe     = 1'b1;
      w_pw     = 1'b0;
      w_val    = pc_plus_one_in;
      w_clr    = 1'b0;
      w_ack    = '0;

      if (int_done && active_q) begin
         active_d = 1'b0;
      end

      case (state_q)
         S_BOOT: begin
            w_pw    = 1'b1;
            w_val   = RESET_PC;
            w_clr   = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (w_take_int) begin
               // A redirect in the same cycle is where execution must resume.
               w_clr   = 1'b1;
               idx_d   = w_low_idx;
               saved_d = branch_req ? branch_target : pc_plus_one_in;
               cnt_d   = C_DRAIN_LOAD;
               state_d = S_DRAIN;
            end else if (branch_req) begin
               w_pw  = 1'b1;
               w_val = branch_target;
               w_clr = 1'b1;
            end else if (!stall_req) begin
               w_pw  = 1'b1;
            end
         end
         S_DRAIN: begin
            w_clr = 1'b1;
            if (branch_req) begin
               saved_d = branch_target;
            end
            if (!stall_req) begin
               if (cnt_q == '0) begin
                  state_d = S_VECTOR;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         S_VECTOR: begin
            w_pw     = 1'b1;
            w_val    = w_vec_addr;
            w_clr    = 1'b1;
            w_ack    = NUM_INT'(1) << idx_q;
            active_d = 1'b1;
            state_d  = S_RUN;
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   // Reset overrides the state-derived outputs combinationally.
   assign pc_enable           = reset & w_pe;
   assign pc_write            = reset & w_pw;
   assign pc_write_back_value = reset ? w_val : RESET_PC;
   assign clear_instruction   = ~reset | w_clr;
   assign int_ack             = reset ? w_ack : '0;
   assign saved_pc            = saved_q;
   assign int_active          = active_q;

`ifdef FETCH_SEQ_STALL_CNT_EN
   logic [15:0] stall_cnt_q;
   logic        w_stall_inc;

   assign w_stall_inc = (state_q == S_RUN) & stall_req & ~branch_req & ~w_take_int;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else if (w_stall_inc && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
//=============================================================================
// tb_fetch_sequencer : directed self-checking bench for fetch_sequencer.
// Revision: 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        stall_req;
   logic        branch_req;
   logic [31:0] branch_target;
   logic [31:0] pc_plus_one_in;
   logic [3:0]  int_req;
   logic        int_done;
   logic        pc_enable;
   logic        pc_write;
   logic [31:0] pc_write_back_value;
   logic        clear_instruction;
   logic [31:0] saved_pc;
   logic [3:0]  int_ack;
   logic        int_active;
   logic [15:0] stall_cycles;

   int n_assert = 0;
   int n_fail   = 0;
   logic [15:0] exp_stall3;

   fetch_sequencer #(
      .PC_WIDTH        (32),
      .RESET_PC        (32'd32),
      .INT_VECTOR_BASE (32'h100),
      .NUM_INT         (4),
      .DRAIN_CYCLES    (2)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .stall_req           (stall_req),
      .branch_req          (branch_req),
      .branch_target       (branch_target),
      .pc_plus_one_in      (pc_plus_one_in),
      .int_req             (int_req),
      .int_done            (int_done),
      .pc_enable           (pc_enable),
      .pc_write            (pc_write),
      .pc_write_back_value (pc_write_back_value),
      .clear_instruction   (clear_instruction),
      .saved_pc            (saved_pc),
      .int_ack             (int_ack),
      .int_active          (int_active),
      .stall_cycles        (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_fetch(input string tag, input logic pe, input logic pw,
                            input logic [31:0] val, input logic clr);
      chk({tag, ".pc_enable"}, {31'd0, pc_enable}, {31'd0, pe});
      chk({tag, ".pc_write"},  {31'd0, pc_write},  {31'd0, pw});
      if (pw) chk({tag, ".value"}, pc_write_back_value, val);
      chk({tag, ".clear"}, {31'd0, clear_instruction}, {31'd0, clr});
   endtask

   // Inputs change on the falling edge; checks follow 1 time unit later.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
`ifdef FETCH_SEQ_STALL_CNT_EN
      exp_stall3 = 16'd3;
`else
      exp_stall3 = 16'd0;
`endif
      reset = 1'b0; stall_req = 1'b0; branch_req = 1'b0; branch_target = '0;
      pc_plus_one_in = '0; int_req = '0; int_done = 1'b0;

      step(); #1;
      chk("rst.pc_enable", {31'd0, pc_enable}, 32'd0);
      chk("rst.pc_write", {31'd0, pc_write}, 32'd0);
      chk("rst.value", pc_write_back_value, 32'd32);
      chk("rst.clear", {31'd0, clear_instruction}, 32'd1);
      chk("rst.saved_pc", saved_pc, 32'd0);
      chk("rst.int_ack", {28'd0, int_ack}, 32'd0);
      chk("rst.int_active", {31'd0, int_active}, 32'd0);
      chk("rst.stall_cycles", {16'd0, stall_cycles}, 32'd0);

      step(); reset = 1'b1; #1;
      chk_fetch("boot", 1'b1, 1'b1, 32'd32, 1'b1);

      step(); pc_plus_one_in = 32'h21; #1;
      chk_fetch("run", 1'b1, 1'b1, 32'h21, 1'b0);

      step(); branch_req = 1'b1; stall_req = 1'b1; branch_target = 32'h80; #1;
      chk_fetch("branch_over_stall", 1'b1, 1'b1, 32'h80, 1'b1);

      step(); branch_req = 1'b0; stall_req = 1'b1; #1;
      chk_fetch("stall1", 1'b1, 1'b0, 32'h0, 1'b0);
      step(); #1;
      chk_fetch("stall2", 1'b1, 1'b0, 32'h0, 1'b0);
      step(); int_req = 4'b0110; pc_plus_one_in = 32'h41; #1;
      chk_fetch("int_blocked_by_stall", 1'b1, 1'b0, 32'h0, 1'b0);

      step(); stall_req = 1'b0; #1;
      chk("stall_cycles", {16'd0, stall_cycles}, {16'd0, exp_stall3});
      chk_fetch("int_entry", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("int_entry.ack", {28'd0, int_ack}, 32'd0);

      step(); int_req = 4'b0000; stall_req = 1'b1; #1;
      chk("drain.saved_pc", saved_pc, 32'h41);
      chk_fetch("drain_stall", 1'b1, 1'b0, 32'h0, 1'b1);
      step(); stall_req = 1'b0; #1;
      chk_fetch("drain_a", 1'b1, 1'b0, 32'h0, 1'b1);
      step(); #1;
      chk_fetch("drain_b", 1'b1, 1'b0, 32'h0, 1'b1);
      chk("drain_b.ack", {28'd0, int_ack}, 32'd0);

      step(); #1;
      chk_fetch("vector", 1'b1, 1'b1, 32'h101, 1'b1);
      chk("vector.ack", {28'd0, int_ack}, 32'b0010);
      chk("vector.active_pre", {31'd0, int_active}, 32'd0);

      step(); int_req = 4'b0001; pc_plus_one_in = 32'h50; #1;
      chk("active", {31'd0, int_active}, 32'd1);
      chk_fetch("no_nesting", 1'b1, 1'b1, 32'h50, 1'b0);
      chk("no_nesting.ack", {28'd0, int_ack}, 32'd0);

      step(); int_done = 1'b1; #1;
      chk_fetch("int_done_cycle", 1'b1, 1'b1, 32'h50, 1'b0);

      step(); int_done = 1'b0; pc_plus_one_in = 32'h60; #1;
      chk("active_cleared", {31'd0, int_active}, 32'd0);
      chk_fetch("int_retaken", 1'b1, 1'b0, 32'h0, 1'b1);

      step(); branch_req = 1'b1; branch_target = 32'h90; #1;
      chk("drain2.saved_pc", saved_pc, 32'h60);
      chk_fetch("drain2_branch", 1'b1, 1'b0, 32'h0, 1'b1);

      step(); branch_req = 1'b0; int_req = 4'b0000; #1;
      chk("drain2.saved_branch", saved_pc, 32'h90);
      #2; reset = 1'b0; #1;
      chk("midrst.pc_enable", {31'd0, pc_enable}, 32'd0);
      chk("midrst.pc_write", {31'd0, pc_write}, 32'd0);
      chk("midrst.value", pc_write_back_value, 32'd32);
      chk("midrst.clear", {31'd0, clear_instruction}, 32'd1);
      chk("midrst.saved_pc", saved_pc, 32'd0);
      chk("midrst.int_active", {31'd0, int_active}, 32'd0);
      chk("midrst.stall_cycles", {16'd0, stall_cycles}, 32'd0);

      step(); #1;
      chk("midrst_hold.int_ack", {28'd0, int_ack}, 32'd0);
      step(); reset = 1'b1; #1;
      chk_fetch("reboot", 1'b1, 1'b1, 32'd32, 1'b1);

      step(); int_req = 4'b1000; branch_req = 1'b1; branch_target = 32'h77; #1;
      chk_fetch("int_with_branch", 1'b1, 1'b0, 32'h0, 1'b1);
      step(); branch_req = 1'b0; #1;
      chk("int_with_branch.saved_pc", saved_pc, 32'h77);
      step(); #1;
      step(); #1;
      chk_fetch("vector3", 1'b1, 1'b1, 32'h103, 1'b1);
      chk("vector3.ack", {28'd0, int_ack}, 32'b1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
